flick_conditioner: RTL and testbench

- Input conditioning stage directly upstream of the bound-flasher LED sequencer.
- Takes the raw, asynchronous, bouncy `flick` push-button and synchronises it to `clk`, then debounces it.
- Produces a clean debounced level plus a single-cycle press pulse; the pulse drives the flasher's `flick` input.
- Also keeps a wrap-around count of accepted presses for debug/status readout.

---
 rtl/flick_cond_pkg.sv | 20 ++
 rtl/sync_chain.sv | 24 ++
 rtl/flick_conditioner.sv | 117 +++++++++++
 tb/tb_flick_conditioner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/flick_cond_pkg.sv
// Shared types and default constants for the flick push-button conditioner.
// The state encoding is fixed so debug readouts stay meaningful across builds.
package flick_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 8;

  function automatic logic is_wait_state(input state_t st);
    return (st == ST_PRESS_WAIT) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Reset-clearable flop chain that brings one asynchronous level into the clk domain.
// Output is the last flop; STAGES must be at least 2.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/flick_conditioner.sv
// Synchronises and debounces the raw flick button; emits a clean level, a one-cycle
// press strobe for the flasher, and a wrapping count of accepted (enabled) presses.
module flick_conditioner
  import flick_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flick_raw,
  input  logic             enable,
  output logic             flick_level,
  output logic             flick_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             busy,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d_i  (flick_raw),
    .q_o  (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  // cnt holds how many consecutive samples have agreed with the pending new level;
  // any disagreeing sample drops straight back to the last stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = ONE_CNT;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = enable;
          count_d = count_q + {{(CNT_W-1){1'b0}}, enable};
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = ONE_CNT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign flick_level = level_q;
  assign flick_pulse = pulse_q;
  assign press_count = count_q;
  assign busy        = is_wait_state(state_q);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Self-checking bench for flick_conditioner: expected pulse edges are queued as
// presses are driven and matched against every observed pulse.
module tb_flick_conditioner;
  import flick_cond_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int W    = 8;
  localparam int LAT  = SYNC + DEB;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         flick_raw = 1'b0;
  logic         enable    = 1'b1;
  logic         flick_level;
  logic         flick_pulse;
  logic [W-1:0] press_count;
  logic         busy;
  state_t       dbg_state;

  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           first_edge = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_pulse;
  logic [W-1:0] exp_count = '0;
  logic [5:0]   bounce_pat;

  flick_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flick_raw  (flick_raw),
    .enable     (enable),
    .flick_level(flick_level),
    .flick_pulse(flick_pulse),
    .press_count(press_count),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every observed pulse must match the oldest queued edge number
  always @(negedge clk) begin
    if (flick_pulse) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", cyc, 32'hffff_ffff);
      end else begin
        exp_pulse = exp_q.pop_front();
        check("pulse_cycle", cyc, exp_pulse);
      end
    end
  end

  // driver tasks; all called at a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drive_press();
    flick_raw  = 1'b1;
    first_edge = cyc + 1;
    if (enable) begin
      exp_q.push_back(32'(first_edge + LAT - 1));
      exp_count++;
    end
  endtask

  task automatic drive_release();
    flick_raw  = 1'b0;
    first_edge = cyc + 1;
  endtask

  task automatic check_release(input string tag);
    drive_release();
    wait_cyc(first_edge + LAT - 2);
    check({tag, "_level_before"}, flick_level, 1);
    wait_cyc(first_edge + LAT - 1);
    check({tag, "_level_after"}, flick_level, 0);
    check({tag, "_busy"}, busy, 0);
    tick(2);
  endtask

  initial begin
    // reset with raw low, then idle
    tick(3);
    check("reset_outputs", {busy, flick_level, flick_pulse, press_count}, '0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_outputs", {busy, flick_level, flick_pulse, press_count}, '0);
    end

    // clean press and release
    drive_press();
    wait_cyc(first_edge + 2);
    check("press_busy", busy, 1);
    wait_cyc(first_edge + LAT - 2);
    check("press_level_before", flick_level, 0);
    wait_cyc(first_edge + LAT - 1);
    check("press_level_after", flick_level, 1);
    check("press_count_1", press_count, exp_count);
    wait_cyc(first_edge + LAT + 2);
    check("held_state", dbg_state, ST_HELD);
    check_release("clean_rel");

    // press bounce 1,1,0,1,1,0 then steady high
    bounce_pat = 6'b110110;
    for (int i = 5; i >= 0; i--) begin
      flick_raw = bounce_pat[i];
      tick(1);
    end
    drive_press();
    wait_cyc(first_edge + LAT - 1);
    check("bounce_level", flick_level, 1);
    check("bounce_count", press_count, exp_count);
    tick(3);

    // release bounce 0,0,1 then high again: level must hold
    flick_raw = 1'b0;
    tick(2);
    flick_raw = 1'b1;
    tick(10);
    check("rel_bounce_level", flick_level, 1);
    check("rel_bounce_busy", busy, 0);

    // long hold gives one pulse, then second press
    tick(50);
    check("hold_count", press_count, exp_count);
    check_release("hold_rel");
    drive_press();
    wait_cyc(first_edge + LAT - 1);
    check("second_press_count", press_count, 8'd3);
    tick(2);
    check_release("second_rel");

    // press accepted with enable low, then enable raised while held
    enable = 1'b0;
    drive_press();
    wait_cyc(first_edge + LAT);
    check("dis_level", flick_level, 1);
    enable = 1'b1;
    tick(10);
    check("dis_count", press_count, exp_count);
    check("dis_state", dbg_state, ST_HELD);
    check_release("dis_rel");

    // reset in the middle of PRESS_WAIT with cnt=2
    flick_raw  = 1'b1;
    first_edge = cyc + 1;
    wait_cyc(first_edge + 3);
    check("mid_state", dbg_state, ST_PRESS_WAIT);
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {busy, flick_level, flick_pulse, press_count}, '0);
    exp_count = '0;
    tick(2);
    check("mid_reset_hold", {busy, flick_level, flick_pulse, press_count}, '0);
    reset = 1'b1;
    first_edge = cyc + 1;
    exp_q.push_back(32'(first_edge + LAT - 1));
    exp_count++;
    wait_cyc(first_edge + LAT - 2);
    check("post_reset_level_before", flick_level, 0);
    wait_cyc(first_edge + LAT - 1);
    check("post_reset_level_after", flick_level, 1);
    check("post_reset_count", press_count, exp_count);
    tick(2);
    check_release("post_reset_rel");

    // 255 more presses wrap the count to zero
    for (int i = 0; i < 255; i++) begin
      drive_press();
      tick(LAT);
      check("wrap_loop_count", press_count, exp_count);
      tick($urandom_range(0, 3));
      drive_release();
      tick($urandom_range(LAT, LAT + 3));
    end
    check("count_wrap", press_count, 0);

    tick(10);
    check("pulse_missing", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
